vs_store_seq: RTL
=================

Name: vs_store_seq

Overview:
Sequencer for vector-store (VS_FORMAT) instructions. ID-stage decode flags a store with MemWrite=1 and ALUcntrl=ALU_LOAD_STORE. This block then walks the vector register elements one at a time and issues one word write per element on the shared data-memory write port. It stalls the scalar pipeline until the last element is accepted.

Parameters:
VLMAX, 8, maximum elements per vector register (power of 2, ≥2)
ELEM_W, 32, element / memory data width in bits
ADDR_W, 32, byte address width
VREG_AW, 5, vector register index width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: VS instruction in EX, operands valid
base_addr  in  ADDR_W  scalar rs1 value (start address)
vl  in  $clog2(VLMAX)+1  active vector length, sampled at start
vs3  in  VREG_AW  source vector register index, sampled at start
vrf_rd_reg  out  VREG_AW  vector RF read register (latched vs3)
vrf_rd_elem  out  $clog2(VLMAX)  vector RF element index
vrf_rd_data  in  ELEM_W  element data, combinational read
mem_req  out  1  memory write request
mem_addr  out  ADDR_W  byte address of current element
mem_wdata  out  ELEM_W  = vrf_rd_data while mem_req
mem_ready  in  1  memory accepts request this cycle
stall  out  1  freeze IF/ID/EX pipeline registers
done  out  1  one-cycle pulse: store sequence complete
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, idx=0, all latched regs=0. Outputs: mem_req=0, done=0, busy=0, stall=0, mem_addr=0, vrf_rd_elem=0, vrf_rd_reg=0.
- FSM states: IDLE, XFER, DONE.
  - IDLE + start, eff_vl≠0: latch base_addr, vs3, eff_vl; idx←0; go to XFER.
  - IDLE + start, eff_vl=0: go to DONE. No memory traffic.
  - XFER: mem_req=1, mem_addr=base+idx*(ELEM_W/8), vrf_rd_elem=idx.
    - mem_ready=0: hold all outputs stable (request must not drop or change).
    - mem_ready=1 and idx<eff_vl−1: idx++.
    - mem_ready=1 and idx=eff_vl−1: go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- eff_vl = min(vl, VLMAX). Values above VLMAX are clamped, not wrapped.
- Address arithmetic is modulo 2^ADDR_W. Wrap past the top is legal and is not flagged.
- stall = start | busy (combinational). Covers the start cycle through the DONE cycle inclusive. stall=0 in the cycle after done.
- Latency with mem_ready tied to 1: start at cycle T, requests in T+1..T+eff_vl, done at T+eff_vl+1.
- start while busy: ignored. The pipeline is stalled, so this is a protocol error; an assertion flags it in simulation.
- Reset asserted mid-sequence: immediate return to IDLE. The partially written vector is not rolled back.
- mem_ready outside XFER: ignored.

Optional Feature:
- Macro VS_STRIDE_EN.
- Defined: adds input stride [ADDR_W-1:0] (scalar rs2, signed byte stride), sampled at start. mem_addr=base+idx*stride, using a running accumulator (no multiplier). stride=0 writes every element to the same address.
- Undefined: port absent; unit stride of ELEM_W/8 bytes.

Decomposition:
- Add to constants.vh: state encodings VSS_IDLE=2'd0, VSS_XFER=2'd1, VSS_DONE=2'd2; VS_ELEM_BYTES=ELEM_W/8.
- Add VS_STRIDE_EN (commented out by default) to config.vh.
- One sub-module, vs_addr_gen: address accumulator with load (base) and step (element stride) inputs. Instantiated once. The FSM and idx counter stay in vs_store_seq.

Test Plan:
1. mem_ready=1, base=0x1000, vl=4, vs3=2 → mem_addr 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles; vrf_rd_reg=2; done at T+5; stall high T..T+5.
2. vl=3, mem_ready low for 2 cycles on element 1 → mem_addr=0x1004 and mem_wdata held stable 3 cycles; exactly 3 accepted writes; done at T+6.
3. vl=0 → no mem_req; done at T+1; stall high for 2 cycles only.
4. vl=VLMAX+3 → exactly VLMAX writes; last address base+4*(VLMAX−1).
5. reset pulled low during element 2 of vl=8 → same-cycle mem_req=0, busy=0, stall=0. A new start after reset release runs a full sequence from idx 0.
6. VS_STRIDE_EN, base=0x2000, stride=−8, vl=3 → addresses 0x2000, 0x1FF8, 0x1FF0. A second run with base=0xFFFFFFFC, unit stride, vl=2 → 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/vs_store_seq_pkg.sv
// Shared types and helpers for the vector-store sequencer.
//   vsState_e    : sequencer FSM encoding (IDLE / XFER / DONE)
//   vsElemBytes  : byte size of one element, the default unit stride
package vs_store_seq_pkg;

  typedef enum logic [1:0] {
    VSS_IDLE = 2'd0,
    VSS_XFER = 2'd1,
    VSS_DONE = 2'd2
  } vsState_e;

  function automatic int vsElemBytes(input int elemW);
    return elemW / 8;
  endfunction

endpackage

// File: rtl/vs_store_seq_addr_gen.sv
// Address accumulator for the vector-store sequencer.
// Ports:
//   clock, reset : system clock, async active-low reset
//   load         : capture base as the current address and latch stride
//   step         : advance the current address by the latched stride
//   base, stride : start address and byte stride (two's complement)
//   addr         : current byte address (wraps modulo 2^ADDR_W)
module vs_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] strideQ;

  // Running sum instead of idx*stride keeps the path to a single adder.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr    <= '0;
      strideQ <= '0;
    end else if (load) begin
      addr    <= base;
      strideQ <= stride;
    end else if (step) begin
      addr    <= addr + strideQ;
    end
  end

endmodule

// File: rtl/vs_store_seq.sv
// Vector-store sequencer: walks the elements of one vector register and
// issues one word write per element on the shared data-memory port,
// stalling the scalar pipeline for the whole sequence.
// Config macro: VS_STRIDE_EN adds the 'stride' input (signed byte stride,
// sampled at start); without it the stride is ELEM_W/8 bytes.
// Ports:
//   clock, reset           : system clock, async active-low reset
//   start                  : one-cycle pulse, VS instruction in EX
//   base_addr, vl, vs3     : start address, vector length, source vreg
//   stride                 : (VS_STRIDE_EN only) byte stride
//   vrf_rd_reg/elem/data   : combinational vector RF read port
//   mem_req/addr/wdata     : memory write request, held until mem_ready
//   mem_ready              : memory accepts request this cycle
//   stall, done, busy      : pipeline freeze, completion pulse, activity
//
// state    | meaning
// ---------+-------------------------------------------------
// VSS_IDLE | waiting for start
// VSS_XFER | requesting the write of element idx
// VSS_DONE | one-cycle completion pulse, then back to idle
module vs_store_seq
  import vs_store_seq_pkg::*;
#(
  parameter int VLMAX   = 8,
  parameter int ELEM_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int VREG_AW = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
`ifdef VS_STRIDE_EN
  input  logic [ADDR_W-1:0]          stride,
`endif
  input  logic [$clog2(VLMAX):0]     vl,
  input  logic [VREG_AW-1:0]         vs3,
  output logic [VREG_AW-1:0]         vrf_rd_reg,
  output logic [$clog2(VLMAX)-1:0]   vrf_rd_elem,
  input  logic [ELEM_W-1:0]          vrf_rd_data,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [ELEM_W-1:0]          mem_wdata,
  input  logic                       mem_ready,
  output logic                       stall,
  output logic                       done,
  output logic                       busy
);

  localparam int VL_W  = $clog2(VLMAX) + 1;
  localparam int IDX_W = $clog2(VLMAX);

  vsState_e          state, nextState;
  logic [VL_W-1:0]   effVl, effVlQ;
  logic [IDX_W-1:0]  idx;
  logic [VREG_AW-1:0] vregQ;
  logic              lastElem;
  logic              loadSeq;
  logic              stepSeq;
  logic [ADDR_W-1:0] strideIn;

  // Lengths above VLMAX saturate rather than wrap.
  assign effVl    = (vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : vl;
  assign lastElem = (VL_W'(idx) == (effVlQ - VL_W'(1)));
  assign loadSeq  = (state == VSS_IDLE) && start && (effVl != '0);
  assign stepSeq  = (state == VSS_XFER) && mem_ready && !lastElem;

`ifdef VS_STRIDE_EN
  assign strideIn = stride;
`else
  assign strideIn = ADDR_W'(vsElemBytes(ELEM_W));
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= VSS_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      VSS_IDLE: if (start) nextState = (effVl == '0) ? VSS_DONE : VSS_XFER;
      VSS_XFER: if (mem_ready && lastElem) nextState = VSS_DONE;
      VSS_DONE: nextState = VSS_IDLE;
      default:  nextState = VSS_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state == VSS_XFER);
    done      = (state == VSS_DONE);
    busy      = (state != VSS_IDLE);
    stall     = start | busy;
    mem_wdata = mem_req ? vrf_rd_data : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      effVlQ <= '0;
      vregQ  <= '0;
      idx    <= '0;
    end else if (loadSeq) begin
      effVlQ <= effVl;
      vregQ  <= vs3;
      idx    <= '0;
    end else if (stepSeq) begin
      idx    <= idx + IDX_W'(1);
    end
  end

  vs_addr_gen #(.ADDR_W(ADDR_W)) uAddrGen (
    .clock  (clock),
    .reset  (reset),
    .load   (loadSeq),
    .step   (stepSeq),
    .base   (base_addr),
    .stride (strideIn),
    .addr   (mem_addr)
  );

  assign vrf_rd_reg  = vregQ;
  assign vrf_rd_elem = idx;

`ifndef SYNTHESIS
  // The pipeline is frozen while busy, so a second start is a protocol error.
  startWhileBusy: assert property (@(posedge clock) disable iff (!reset) !(start && busy))
    else $error("vs_store_seq: start asserted while busy");
`endif

endmodule
